mem_bank_proc: RTL and testbench

- Parametrised two-bank memory processor: successor to the board-level input/output bank lab block.
- Holds an input bank and an output bank, each 2**ADDR_W words of DATA_W bits, with a user address pointer and a registered display read port.
- Adds a one-shot sweep engine that streams the whole input bank through a mode-selectable half-word ALU into the output bank.
- Sits between the debounced/pulsed button logic and the 7-segment display driver.

---
 rtl/mem_bank_proc.sv | 131 +++++++++++++
 tb/tb_mem_bank_proc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_proc.sv
// Two-bank memory processor: user-addressed input bank, swept output bank,
// registered display port and a one-shot half-word ALU sweep engine.
module mem_bank_proc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              wr_in,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              clr_addr,
  input  logic              sel_in,
  input  logic              sel_out,
  input  logic              run,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic              bank_sel,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              done
);

  localparam int H = DATA_W / 2;
  localparam int D = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   PTR_LAST = (ADDR_W + 1)'(D);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(D - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     ptr_reg;
  logic [ADDR_W:0]     ptr_prev;
  logic [1:0]          mode_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                bank_sel_reg;
  logic [DATA_W-1:0]   disp_reg;
  logic [DATA_W-1:0]   pipe_reg;

  logic [DATA_W-1:0] in_bank  [D];
  logic [DATA_W-1:0] out_bank [D];

  function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] w,
                                            input logic [1:0]        m);
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    hi = {{H{1'b0}}, w[DATA_W-1:H]};
    lo = {{H{1'b0}}, w[H-1:0]};
    case (m)
      2'd0:    alu = hi + lo;
      2'd1:    alu = hi - lo;
      2'd2:    alu = (hi > lo) ? hi : lo;
      default: alu = w;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state logic; the sweep runs D+1 cycles to drain the pipeline
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (run) state_next = ST_SWEEP;
      ST_SWEEP: if (ptr_reg == PTR_LAST) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_reg == ST_SWEEP);
    done = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg  <= '0;
      mode_reg <= 2'd0;
    end else if (state_reg == ST_IDLE && run) begin
      ptr_reg  <= '0;
      mode_reg <= mode;
    end else if (busy) begin
      ptr_reg  <= ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      bank_sel_reg <= 1'b1;
      disp_reg     <= '0;
    end else begin
      if (!busy) begin
        if (clr_addr)
          addr_reg <= '0;
        else if (inc_pulse && dec_pulse)
          addr_reg <= addr_reg;
        else if (dec_pulse) begin
          if (addr_reg != '0) addr_reg <= addr_reg - 1'b1;
        end else if (inc_pulse) begin
          if (addr_reg != ADDR_MAX) addr_reg <= addr_reg + 1'b1;
        end
      end
      if (sel_out)     bank_sel_reg <= 1'b0;
      else if (sel_in) bank_sel_reg <= 1'b1;
      disp_reg <= bank_sel_reg ? in_bank[addr_reg] : out_bank[addr_reg];
    end
  end

  assign ptr_prev = ptr_reg - 1'b1;

  // Bank storage is never reset; rst_n only gates writes so a reset aborts cleanly
  always_ff @(posedge clk) begin
    if (rst_n && busy) begin
      if (ptr_reg != PTR_LAST) pipe_reg <= in_bank[ptr_reg[ADDR_W-1:0]];
      if (ptr_reg != '0) out_bank[ptr_prev[ADDR_W-1:0]] <= alu(pipe_reg, mode_reg);
    end
    if (rst_n && wr_in && !busy) in_bank[addr_reg] <= sw_data;
  end

  assign addr      = addr_reg;
  assign bank_sel  = bank_sel_reg;
  assign disp_data = disp_reg;

endmodule

// File: tb/tb_mem_bank_proc.sv
// Randomised self-checking bench for mem_bank_proc against an array-level
// model of both banks, the address pointer and the display select.
module tb_mem_bank_proc;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sw_data = '0;
  logic          wr_in = 0, inc_pulse = 0, dec_pulse = 0, clr_addr = 0;
  logic          sel_in = 0, sel_out = 0, run = 0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] addr;
  logic          bank_sel;
  logic [DW-1:0] disp_data;
  logic          busy, done;

  mem_bank_proc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .wr_in(wr_in),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .clr_addr(clr_addr),
    .sel_in(sel_in), .sel_out(sel_out), .run(run), .mode(mode),
    .addr(addr), .bank_sel(bank_sel), .disp_data(disp_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_m  [D];
  logic [DW-1:0] out_m [D];
  bit            in_known  [D];
  bit            out_known [D];
  int            addr_m = 0;
  bit            sel_m  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] w, input int m);
    int hi, lo;
    hi = int'(w) / 256;
    lo = int'(w) % 256;
    case (m)
      0:       return DW'(hi + lo);
      1:       return DW'(hi - lo);
      2:       return DW'((hi > lo) ? hi : lo);
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    wr_in = 0; inc_pulse = 0; dec_pulse = 0; clr_addr = 0;
    sel_in = 0; sel_out = 0; run = 0;
  endtask

  task automatic model_sel(input bit si, input bit so);
    if (so)      sel_m = 1'b0;
    else if (si) sel_m = 1'b1;
  endtask

  // One idle-FSM cycle with user inputs; checks the edge's effect on the outputs.
  task automatic op(input bit w, input bit i, input bit d, input bit c,
                    input bit si, input bit so, input logic [DW-1:0] data);
    logic [DW-1:0] exp_disp;
    bit            disp_ok;
    exp_disp = sel_m ? in_m[addr_m] : out_m[addr_m];
    disp_ok  = sel_m ? in_known[addr_m] : out_known[addr_m];
    wr_in = w; inc_pulse = i; dec_pulse = d; clr_addr = c;
    sel_in = si; sel_out = so; sw_data = data;
    if (w) begin
      in_m[addr_m]     = data;
      in_known[addr_m] = 1'b1;
    end
    if (c)           addr_m = 0;
    else if (i && d) addr_m = addr_m;
    else if (d)      addr_m = (addr_m > 0) ? addr_m - 1 : 0;
    else if (i)      addr_m = (addr_m < D - 1) ? addr_m + 1 : D - 1;
    model_sel(si, so);
    tick();
    clear_in();
    check("addr", 32'(addr), 32'(addr_m));
    check("bank_sel", 32'(bank_sel), 32'(sel_m));
    if (disp_ok) check("disp", 32'(disp_data), 32'(exp_disp));
  endtask

  task automatic check_all(input bit in_side);
    op(0, 0, 0, 1, in_side, !in_side, '0);
    repeat (D) op(0, 1, 0, 0, 0, 0, '0);
  endtask

  task automatic sweep(input int m, input bit noisy);
    int n;
    int a0;
    bit s0;
    mode = 2'(m);
    run = 1;
    tick();
    clear_in();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      check("done_in_sweep", 32'(done), 32'd0);
      if (noisy) begin
        wr_in = 1'($urandom % 2); sw_data = DW'($urandom);
        inc_pulse = 1'($urandom % 2); dec_pulse = 1'($urandom % 2);
        clr_addr = 1'($urandom % 2); run = 1'($urandom % 2);
        mode = 2'($urandom);
        sel_in = 1'($urandom % 2); sel_out = 1'($urandom % 2);
        if (n == 1) begin sel_in = 1; sel_out = 1; end
        model_sel(sel_in, sel_out);
      end
      tick();
      clear_in();
      if (noisy && n == 1) check("sel_both", 32'(bank_sel), 32'd0);
    end
    check("busy_len", 32'(n), 32'(D + 1));
    check("done_pulse", 32'(done), 32'd1);
    for (int k = 0; k < D; k++) begin
      out_m[k]     = ref_alu(in_m[k], m);
      out_known[k] = in_known[k];
    end
    a0 = addr_m;
    s0 = sel_m;
    run = 1;
    tick();
    clear_in();
    check("done_once", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    tick();
    check("no_restart", 32'(busy), 32'd0);
    check("addr_locked", 32'(addr), 32'(a0));
    check("sel_hold", 32'(bank_sel), 32'(s0));
    $display("sweep mode=%0d busy_cycles=%0d", m, n);
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin
      in_known[k] = 0; out_known[k] = 0; in_m[k] = '0; out_m[k] = '0;
    end
    clear_in();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_sel", 32'(bank_sel), 32'd1);
    check("rst_disp", 32'(disp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // write / readback
    op(1, 0, 0, 0, 0, 0, 16'h1234);
    op(0, 1, 0, 0, 0, 0, '0);
    op(1, 0, 0, 0, 0, 0, 16'hABCD);
    op(0, 0, 0, 1, 1, 0, '0);
    op(0, 1, 0, 0, 0, 0, '0);
    check("rb0", 32'(disp_data), 32'h1234);
    op(0, 0, 0, 0, 0, 0, '0);
    check("rb1", 32'(disp_data), 32'hABCD);

    // ADD sweep
    op(1, 0, 0, 0, 0, 0, 16'hFFFF);
    for (int k = 2; k < D; k++) begin
      op(0, 1, 0, 0, 0, 0, '0);
      op(1, 0, 0, 0, 0, 0, '0);
    end
    sweep(0, 0);
    check_all(0);

    // SUB / MAX / COPY with lockout noise and mid-sweep mode changes
    op(0, 0, 0, 1, 1, 0, '0);
    op(1, 0, 0, 0, 0, 0, 16'h0305);
    for (int m = 1; m < 4; m++) begin
      sweep(m, 1);
      check_all(0);
    end
    check_all(1);

    // address bounds
    op(0, 0, 0, 1, 0, 0, '0);
    repeat (20) op(0, 1, 0, 0, 0, 0, '0);
    check("addr_sat_hi", 32'(addr), 32'd15);
    repeat (20) op(0, 0, 1, 0, 0, 0, '0);
    check("addr_sat_lo", 32'(addr), 32'd0);
    repeat (5) op(0, 1, 0, 0, 0, 0, '0);
    op(0, 1, 1, 0, 0, 0, '0);
    check("addr_incdec", 32'(addr), 32'd5);
    op(0, 1, 0, 1, 0, 0, '0);
    check("addr_clrinc", 32'(addr), 32'd0);

    // randomised traffic and sweeps
    for (int r = 0; r < 4; r++) begin
      repeat (60)
        op($urandom % 3 == 0, $urandom % 3 == 0, $urandom % 3 == 0, $urandom % 10 == 0,
           $urandom % 4 == 0, $urandom % 4 == 0, DW'($urandom));
      sweep(int'($urandom % 4), 1);
      check_all(0);
      check_all(1);
    end

    // reset in the middle of a sweep
    op(0, 0, 0, 1, 0, 0, '0);
    repeat (7) op(0, 1, 0, 0, 0, 0, '0);
    mode = 2'd0;
    run = 1;
    tick();
    clear_in();
    repeat (5) tick();
    #2;
    rst_n = 0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_disp", 32'(disp_data), 32'd0);
    check("mid_addr", 32'(addr), 32'd0);
    check("mid_sel", 32'(bank_sel), 32'd1);
    for (int k = 0; k < 4; k++) out_m[k] = ref_alu(in_m[k], 0);
    out_known[4] = 0;
    addr_m = 0;
    sel_m  = 1'b1;
    @(negedge clk);
    rst_n = 1;
    tick();
    check_all(0);
    check_all(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
